// File: rtl/ucsbece154b_icache.sv
`default_nettype none
// ============================================================================
//  Module   : ucsbece154b_icache
//  Purpose  : Direct-mapped instruction cache for the pipelined core's fetch
//             port. A hit returns the instruction combinationally in the same
//             cycle. A miss raises stall_o and refills one line from backing
//             memory using a request/ack handshake followed by data beats.
//  Ports    : clk          - single clock, all state updates on posedge
//             reset        - synchronous, active-low (low = reset)
//             pc_i         - fetch byte address (PCF)
//             instr_o      - instruction for pc_i, valid while stall_o = 0
//             stall_o      - instruction unavailable, core must hold PC
//             mem_req_o    - refill request, held until mem_ack_i
//             mem_addr_o   - line-aligned refill byte address
//             mem_ack_i    - memory accepted the request
//             mem_valid_i  - one refill beat is valid this cycle
//             mem_data_i   - refill beat data, word 0 first
//             hit_count_o  - saturating hit counter  (ICACHE_PERF_EN only)
//             miss_count_o - saturating miss counter (ICACHE_PERF_EN only)
//  Options  : define ICACHE_PERF_EN to add the hit/miss counters.
//  Revision : 1.0 - initial release
// ============================================================================
module ucsbece154b_icache #(
   parameter int NUM_SETS      = 8,
   parameter int BLOCK_WORDS   = 4,
   parameter int MEM_ADDR_BITS = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              pc_i,
   output logic [31:0]              instr_o,
   output logic                     stall_o,
   output logic                     mem_req_o,
   output logic [MEM_ADDR_BITS-1:0] mem_addr_o,
   input  logic                     mem_ack_i,
   input  logic                     mem_valid_i,
   input  logic [31:0]              mem_data_i
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0]              hit_count_o,
   output logic [31:0]              miss_count_o
`endif
);

   localparam int OFF_BITS = $clog2(BLOCK_WORDS);
   localparam int IDX_BITS = $clog2(NUM_SETS);
   localparam int TAG_BITS = 32 - IDX_BITS - OFF_BITS - 2;

   localparam logic [31:0]         c_NOP       = 32'h0000_0013;
   localparam logic [OFF_BITS-1:0] c_LAST_BEAT = OFF_BITS'(BLOCK_WORDS - 1);
   localparam logic [OFF_BITS-1:0] c_BEAT_ONE  = OFF_BITS'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_REFILL = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_stateNext;

   logic [31:0]          r_data [NUM_SETS][BLOCK_WORDS];
   logic [TAG_BITS-1:0]  r_tags [NUM_SETS];
   logic [NUM_SETS-1:0]  r_valid;

   logic [TAG_BITS-1:0]  r_missTag;
   logic [IDX_BITS-1:0]  r_missIndex;
   logic [OFF_BITS-1:0]  r_beatCnt;

   logic [OFF_BITS-1:0]  w_offset;
   logic [IDX_BITS-1:0]  w_index;
   logic [TAG_BITS-1:0]  w_tag;
   logic                 w_hit;
   logic                 w_missLatch;
   logic                 w_beatWrite;
   logic                 w_lastBeat;
   logic [31:0]          w_lineAddr;
   logic                 w_unused_pcLow;

   // Byte-within-word bits never select anything in a word-aligned fetch.
   assign w_unused_pcLow = ^pc_i[1:0];

   assign w_offset = pc_i[OFF_BITS+1:2];
   assign w_index  = pc_i[OFF_BITS+IDX_BITS+1:OFF_BITS+2];
   assign w_tag    = pc_i[31:OFF_BITS+IDX_BITS+2];
   assign w_hit    = r_valid[w_index] && (r_tags[w_index] == w_tag);

   assign w_lineAddr = {r_missTag, r_missIndex, {(OFF_BITS+2){1'b0}}};
   assign mem_addr_o = reset ? MEM_ADDR_BITS'(w_lineAddr) : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      instr_o     = c_NOP;
      stall_o     = 1'b0;
      mem_req_o   = 1'b0;
      w_missLatch = 1'b0;
      w_beatWrite = 1'b0;
      w_lastBeat  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               instr_o = r_data[w_index][w_offset];
            end else begin
               stall_o     = 1'b1;
               w_missLatch = 1'b1;
               w_stateNext = S_REQ;
            end
         end
         S_REQ: begin
            stall_o   = 1'b1;
            mem_req_o = 1'b1;
            if (mem_ack_i) begin
               w_stateNext = S_REFILL;
            end
         end
         S_REFILL: begin
            stall_o = 1'b1;
            if (mem_valid_i) begin
               w_beatWrite = 1'b1;
               if (r_beatCnt == c_LAST_BEAT) begin
                  w_lastBeat  = 1'b1;
                  w_stateNext = S_IDLE;
               end
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase

      // Reset overrides everything: no stall, no request, no array writes.
      if (!reset) begin
         w_stateNext = S_IDLE;
         instr_o     = c_NOP;
         stall_o     = 1'b0;
         mem_req_o   = 1'b0;
         w_missLatch = 1'b0;
         w_beatWrite = 1'b0;
         w_lastBeat  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid     <= '0;
         r_beatCnt   <= '0;
         r_missTag   <= '0;
         r_missIndex <= '0;
      end else begin
         if (w_missLatch) begin
            r_missTag   <= w_tag;
            r_missIndex <= w_index;
         end
         if ((r_state == S_REQ) && mem_ack_i) begin
            r_beatCnt <= '0;
         end else if (w_beatWrite) begin
            r_beatCnt <= r_beatCnt + c_BEAT_ONE;
         end
         // The line only becomes visible once every word has landed.
         if (w_lastBeat) begin
            r_valid[r_missIndex] <= 1'b1;
         end
      end
   end

   // Data and tag storage carry no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (w_beatWrite) begin
         r_data[r_missIndex][r_beatCnt] <= mem_data_i;
      end
      if (w_lastBeat) begin
         r_tags[r_missIndex] <= r_missTag;
      end
   end

`ifdef ICACHE_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_count_o  <= '0;
         miss_count_o <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_hit && (hit_count_o != 32'hFFFF_FFFF)) begin
            hit_count_o <= hit_count_o + 32'd1;
         end
         if (w_missLatch && (miss_count_o != 32'hFFFF_FFFF)) begin
            miss_count_o <= miss_count_o + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_icache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ucsbece154b_icache
//  Purpose  : Self-checking bench for ucsbece154b_icache. A behavioural memory
//             answers refill requests from a backing word table; expected
//             instructions are queued when a fetch address is driven and
//             compared when the cache delivers an unstalled instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ucsbece154b_icache;

   localparam logic [31:0] c_NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic [31:0] pc_i;
   logic [31:0] instr_o;
   logic        stall_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic        mem_valid_i;
   logic [31:0] mem_data_i;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_count_o;
   logic [31:0] miss_count_o;
`endif

   int errors = 0;
   int checks = 0;

   int ackDelay    = 0;
   int beatGap     = 0;
   int beatsDriven = 0;

   logic [31:0] memWords [logic [31:0]];
   logic [31:0] expQ [$];

   ucsbece154b_icache #(
      .NUM_SETS     (8),
      .BLOCK_WORDS  (4),
      .MEM_ADDR_BITS(32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_i        (pc_i),
      .instr_o     (instr_o),
      .stall_o     (stall_o),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_ack_i   (mem_ack_i),
      .mem_valid_i (mem_valid_i),
      .mem_data_i  (mem_data_i)
`ifdef ICACHE_PERF_EN
      ,
      .hit_count_o (hit_count_o),
      .miss_count_o(miss_count_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memRead(input logic [31:0] addr);
      logic [31:0] a;
      a = {addr[31:2], 2'b00};
      if (memWords.exists(a)) return memWords[a];
      return 32'hDEAD_0000 ^ a;
   endfunction

   // Behavioural refill memory: acks after ackDelay cycles, then streams
   // the four words of the requested line with beatGap idle cycles between.
   initial begin
      logic [31:0] lineAddr;
      mem_ack_i   = 1'b0;
      mem_valid_i = 1'b0;
      mem_data_i  = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_req_o === 1'b1) begin
            lineAddr = mem_addr_o;
            repeat (ackDelay) @(negedge clk);
            mem_ack_i = 1'b1;
            @(negedge clk);
            mem_ack_i = 1'b0;
            for (int b = 0; b < 4; b++) begin
               mem_valid_i = 1'b1;
               mem_data_i  = memRead(lineAddr + 32'(4 * b));
               beatsDriven = beatsDriven + 1;
               @(negedge clk);
               mem_valid_i = 1'b0;
               mem_data_i  = 32'h0;
               repeat (beatGap) @(negedge clk);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   // Waits (bounded) for the cache to deliver an unstalled instruction,
   // recording stall cycles and the first refill request seen.
   task automatic waitInstr(output logic [31:0] instr, output int stalls,
                            output bit sawReq, output logic [31:0] reqAddr,
                            output bit timedOut);
      instr    = 32'h0;
      stalls   = 0;
      sawReq   = 1'b0;
      reqAddr  = 32'h0;
      timedOut = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if ((mem_req_o === 1'b1) && !sawReq) begin
            sawReq  = 1'b1;
            reqAddr = mem_addr_o;
         end
         if (stall_o === 1'b0) begin
            instr    = instr_o;
            timedOut = 1'b0;
            break;
         end
         stalls++;
      end
   endtask

   task automatic fetch(input logic [31:0] pc, output logic [31:0] instr,
                        output int stalls, output bit sawReq,
                        output logic [31:0] reqAddr, output bit timedOut);
      @(posedge clk);
      #1;
      pc_i = pc;
      expQ.push_back(memRead(pc));
      waitInstr(instr, stalls, sawReq, reqAddr, timedOut);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      pc_i  = 32'h0001_0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %b expected 0", stall_o);
      end
      checks++;
      if (mem_req_o !== 1'b0) begin
         errors++; $display("FAIL reset_req: got %b expected 0", mem_req_o);
      end
      checks++;
      if (instr_o !== c_NOP) begin
         errors++; $display("FAIL reset_instr: got %h expected %h", instr_o, c_NOP);
      end
      checks++;
      if (mem_addr_o !== 32'h0) begin
         errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o);
      end
`ifdef ICACHE_PERF_EN
      checks++;
      if ((hit_count_o !== 32'h0) || (miss_count_o !== 32'h0)) begin
         errors++; $display("FAIL reset_perf: got hit=%0d miss=%0d expected 0/0", hit_count_o, miss_count_o);
      end
`endif
   endtask

   task automatic test_cold_miss();
      logic [31:0] instr, reqAddr, exp;
      int stalls;
      bit sawReq, to;
      @(posedge clk);
      #1;
      reset = 1'b1;
      pc_i  = 32'h0001_0000;
      expQ.push_back(memRead(pc_i));
      waitInstr(instr, stalls, sawReq, reqAddr, to);
      exp = expQ.pop_front();
      checks++;
      if (to || (stalls != 6)) begin
         errors++; $display("FAIL cold_stall_cycles: got %0d (timeout=%0b) expected 6", stalls, to);
      end
      checks++;
      if (!sawReq || (reqAddr !== 32'h0001_0000)) begin
         errors++; $display("FAIL cold_req_addr: got %h (req=%0b) expected 00010000", reqAddr, sawReq);
      end
      checks++;
      if (instr !== exp) begin
         errors++; $display("FAIL cold_instr: got %h expected %h", instr, exp);
      end
   endtask

   task automatic test_same_line_hits();
      logic [31:0] pcs [3];
      logic [31:0] instr, reqAddr, exp;
      int stalls;
      bit sawReq, to;
      pcs[0] = 32'h0001_0004;
      pcs[1] = 32'h0001_0008;
      pcs[2] = 32'h0001_000C;
      for (int i = 0; i < 3; i++) begin
         fetch(pcs[i], instr, stalls, sawReq, reqAddr, to);
         exp = expQ.pop_front();
         checks++;
         if (to || (stalls != 0) || sawReq) begin
            errors++; $display("FAIL hit_nostall[%0d]: got stalls=%0d req=%0b expected 0/0", i, stalls, sawReq);
         end
         checks++;
         if (instr !== exp) begin
            errors++; $display("FAIL hit_instr[%0d]: got %h expected %h", i, instr, exp);
         end
      end
`ifdef ICACHE_PERF_EN
      @(posedge clk);
      #1;
      checks++;
      if ((hit_count_o !== 32'd4) || (miss_count_o !== 32'd1)) begin
         errors++; $display("FAIL perf_counts: got hit=%0d miss=%0d expected 4/1", hit_count_o, miss_count_o);
      end
`endif
   endtask

   task automatic test_conflict();
      logic [31:0] instr, reqAddr, exp;
      int stalls;
      bit sawReq, to;
      fetch(32'h0001_0080, instr, stalls, sawReq, reqAddr, to);
      exp = expQ.pop_front();
      checks++;
      if (to || (stalls != 6) || !sawReq || (reqAddr !== 32'h0001_0080)) begin
         errors++; $display("FAIL conflict_miss: got stalls=%0d addr=%h expected 6/00010080", stalls, reqAddr);
      end
      checks++;
      if (instr !== exp) begin
         errors++; $display("FAIL conflict_instr: got %h expected %h", instr, exp);
      end
      fetch(32'h0001_0084, instr, stalls, sawReq, reqAddr, to);
      exp = expQ.pop_front();
      checks++;
      if (to || (stalls != 0) || (instr !== exp)) begin
         errors++; $display("FAIL conflict_hit: got %h stalls=%0d expected %h/0", instr, stalls, exp);
      end
      fetch(32'h0001_0000, instr, stalls, sawReq, reqAddr, to);
      exp = expQ.pop_front();
      checks++;
      if (to || (stalls != 6) || !sawReq || (reqAddr !== 32'h0001_0000)) begin
         errors++; $display("FAIL evicted_remiss: got stalls=%0d addr=%h expected 6/00010000", stalls, reqAddr);
      end
      checks++;
      if (instr !== exp) begin
         errors++; $display("FAIL evicted_instr: got %h expected %h", instr, exp);
      end
   endtask

   task automatic test_redirect();
      logic [31:0] instr, reqAddr, exp;
      int stalls, base;
      bit sawReq, to, reached;
      ackDelay = 3;
      beatGap  = 2;
      base     = beatsDriven;
      @(posedge clk);
      #1;
      pc_i = 32'h0001_0040;
      reached = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (beatsDriven - base >= 2) begin
            reached = 1'b1;
            break;
         end
      end
      checks++;
      if (!reached) begin
         errors++; $display("FAIL redirect_beats: got %0d beats expected 2", beatsDriven - base);
      end
      @(posedge clk);
      #1;
      pc_i = 32'h0002_0000;
      expQ.push_back(memRead(pc_i));
      waitInstr(instr, stalls, sawReq, reqAddr, to);
      exp = expQ.pop_front();
      checks++;
      if (to || !sawReq || (reqAddr !== 32'h0002_0000)) begin
         errors++; $display("FAIL redirect_req_addr: got %h (req=%0b) expected 00020000", reqAddr, sawReq);
      end
      checks++;
      if (instr !== exp) begin
         errors++; $display("FAIL redirect_instr: got %h expected %h", instr, exp);
      end
      ackDelay = 0;
      beatGap  = 0;
      fetch(32'h0001_0040, instr, stalls, sawReq, reqAddr, to);
      exp = expQ.pop_front();
      checks++;
      if (to || (stalls != 0) || (instr !== exp)) begin
         errors++; $display("FAIL redirect_orig_w0: got %h stalls=%0d expected %h/0", instr, stalls, exp);
      end
      fetch(32'h0001_004C, instr, stalls, sawReq, reqAddr, to);
      exp = expQ.pop_front();
      checks++;
      if (to || (stalls != 0) || (instr !== exp)) begin
         errors++; $display("FAIL redirect_orig_w3: got %h stalls=%0d expected %h/0", instr, stalls, exp);
      end
   endtask

   task automatic test_reset_midrefill();
      logic [31:0] instr, reqAddr, exp;
      int stalls, base;
      bit sawReq, to, reached;
      base = beatsDriven;
      @(posedge clk);
      #1;
      pc_i = 32'h0001_0050;
      reached = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (beatsDriven - base >= 2) begin
            reached = 1'b1;
            break;
         end
      end
      checks++;
      if (!reached) begin
         errors++; $display("FAIL midreset_beats: got %0d beats expected 2", beatsDriven - base);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if ((mem_req_o !== 1'b0) || (stall_o !== 1'b0)) begin
            errors++; $display("FAIL midreset_outputs[%0d]: got req=%b stall=%b expected 0/0", c, mem_req_o, stall_o);
         end
         if (c == 1) begin
            checks++;
            if ((instr_o !== c_NOP) || (mem_addr_o !== 32'h0)) begin
               errors++; $display("FAIL midreset_instr_addr: got %h/%h expected %h/0", instr_o, mem_addr_o, c_NOP);
            end
`ifdef ICACHE_PERF_EN
            checks++;
            if ((hit_count_o !== 32'h0) || (miss_count_o !== 32'h0)) begin
               errors++; $display("FAIL midreset_perf: got hit=%0d miss=%0d expected 0/0", hit_count_o, miss_count_o);
            end
`endif
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      pc_i  = 32'h0001_0040;
      expQ.push_back(memRead(pc_i));
      waitInstr(instr, stalls, sawReq, reqAddr, to);
      exp = expQ.pop_front();
      checks++;
      if (to || (stalls != 6) || !sawReq || (reqAddr !== 32'h0001_0040)) begin
         errors++; $display("FAIL postreset_remiss: got stalls=%0d addr=%h expected 6/00010040", stalls, reqAddr);
      end
      checks++;
      if (instr !== exp) begin
         errors++; $display("FAIL postreset_instr: got %h expected %h", instr, exp);
      end
      fetch(32'h0001_0050, instr, stalls, sawReq, reqAddr, to);
      exp = expQ.pop_front();
      checks++;
      if (to || (stalls != 6) || (instr !== exp)) begin
         errors++; $display("FAIL abandoned_line: got %h stalls=%0d expected %h/6", instr, stalls, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      pc_i  = 32'h0;
      memWords[32'h0001_0000] = 32'h0050_0093;
      memWords[32'h0001_0004] = 32'h0010_0113;
      memWords[32'h0001_0008] = 32'h0020_81B3;
      memWords[32'h0001_000C] = 32'h0000_0013;
      for (int i = 0; i < 4; i++) begin
         memWords[32'h0001_0080 + 32'(4 * i)] = 32'h1111_0000 + 32'(i);
         memWords[32'h0001_0040 + 32'(4 * i)] = 32'h2222_0000 + 32'(i);
         memWords[32'h0002_0000 + 32'(4 * i)] = 32'h3333_0000 + 32'(i);
         memWords[32'h0001_0050 + 32'(4 * i)] = 32'h4444_0000 + 32'(i);
      end

      test_reset();
      test_cold_miss();
      test_same_line_hits();
      test_conflict();
      test_redirect();
      test_reset_midrefill();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ucsbece154b_icache.md
Name: ucsbece154b_icache

Overview:
- Instruction-side responder for the pipelined core's fetch interface: answers the fetch PC with a 32-bit instruction in the same cycle on a hit.
- On a miss, raises a stall and refills one line from backing instruction memory over a request/beat handshake.
- Direct-mapped with valid bits, sits between the core fetch port (PCF/InstrF) and main memory.
- The hazard unit ORs stall_o into StallF/StallD.

Parameters:
- NUM_SETS, 8, number of cache lines; power of 2, ≥2.
- BLOCK_WORDS, 4, 32-bit words per line; power of 2, ≥2.
- MEM_ADDR_BITS, 32, width of the memory-side byte address.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (low = reset).
- pc_i  input  32  fetch byte address from core (PCF).
- instr_o  output  32  instruction for pc_i; valid when stall_o=0.
- stall_o  output  1  1 = instruction not available this cycle; core must hold PC.
- mem_req_o  output  1  refill request; held until mem_ack_i.
- mem_addr_o  output  MEM_ADDR_BITS  line-aligned refill address (low log2(BLOCK_WORDS)+2 bits zero).
- mem_ack_i  input  1  memory accepted request this cycle.
- mem_valid_i  input  1  one refill data beat valid this cycle.
- mem_data_i  input  32  refill data beat, word order 0..BLOCK_WORDS-1.

Behaviour:
- Address split:
  - pc_i[1:0] ignored.
  - offset = pc_i[OFF+1:2], OFF = log2(BLOCK_WORDS).
  - index = next log2(NUM_SETS) bits.
  - tag = remaining upper bits.
- Storage: data array NUM_SETS×BLOCK_WORDS×32; tag array; valid bit per set.
- Hit = valid[index] && tag match. Combinational, zero latency: instr_o = data[index][offset], stall_o = 0.
- States:
  - IDLE: stall_o = !hit.
    - On miss, latch tag/index into miss registers and go to REQ. mem_req_o asserts the next cycle.
  - REQ: mem_req_o = 1, mem_addr_o = {miss tag, miss index, zeros}; stall_o = 1.
    - On mem_ack_i, go to REFILL with beat counter = 0.
  - REFILL: stall_o = 1, mem_req_o = 0.
    - Each mem_valid_i writes mem_data_i to data[miss index][counter] and increments the counter.
    - On the final beat (counter = BLOCK_WORDS-1), write the tag, set valid, and go to IDLE.
    - Beats have no backpressure; gaps between beats are allowed.
- After IDLE is re-entered: re-lookup with the current pc_i. The hit is served with no extra bubble beyond that cycle.
- Miss penalty, zero-wait memory (ack in REQ's first cycle, beats every cycle): 1 (detect) + 1 (REQ) + BLOCK_WORDS cycles.
- While stall_o = 1: instr_o = 32'h00000013 (NOP).
- pc_i change during REQ/REFILL (e.g. core redirect): the refill still completes for the latched line; the new pc_i is looked up in IDLE.
- mem_valid_i in IDLE/REQ: ignored. mem_ack_i outside REQ: ignored.
- Only the miss registers and the line being refilled are written; other sets are untouched.
- Reset (reset = 0, any state, including mid-refill):
  - next state IDLE; all valid bits cleared; counter = 0; mem_req_o = 0.
  - Any refill is abandoned and remaining beats are ignored.
  - While reset is low: stall_o = 0, instr_o = NOP, mem_addr_o = 0.
- Data/tag arrays are not reset.

Optional Feature:
- ICACHE_PERF_EN.
- Defined: adds outputs hit_count_o [31:0] and miss_count_o [31:0].
  - hit_count_o increments once per cycle in IDLE with hit && reset high.
  - miss_count_o increments on each IDLE→REQ transition.
  - Both saturate at 32'hFFFFFFFF and clear to 0 on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold miss: release reset, pc_i = 0x00010000, memory acks in 1 cycle, beats 0x00500093, 0x00100113, 0x002081B3, 0x00000013 back-to-back.
  - stall_o high for 6 cycles; mem_addr_o = 0x00010000.
  - Then instr_o = 0x00500093, stall_o = 0.
- Same-line hits: after the fill, pc_i = 0x00010004, 0x00010008, 0x0001000C.
  - instr_o = 0x00100113, 0x002081B3, 0x00000013; stall_o = 0 every cycle; mem_req_o never asserts.
- Conflict eviction: fill 0x00010000, then pc_i = 0x00010080 (same index, NUM_SETS = 8, BLOCK_WORDS = 4).
  - Miss, refill, then hit on 0x00010080.
  - Returning to 0x00010000 misses again.
- Gapped beats and redirect: mem_ack_i delayed 3 cycles, beats with 2-cycle gaps, pc_i changed to 0x00020000 mid-refill.
  - Original line completes and is valid.
  - Then a new miss is issued with mem_addr_o = 0x00020000.
- Reset mid-refill: reset low after beat 2.
  - mem_req_o = 0 and stall_o = 0 while low.
  - Late beats ignored.
  - After release, the previously filled address misses (valid cleared).
- ICACHE_PERF_EN defined: 1 miss + 3 hit cycles from scenarios 1–2 → miss_count_o = 1, hit_count_o = 4 (includes the post-fill hit cycle); reset → both 0.
